// File: rtl/majority_pkg.sv
// Shared definitions for the majority-vote stream: vote mode encodings and a
// constant-width helper used to size count fields.
package majority_pkg;

  typedef enum logic [1:0] {
    MODE_MAJ = 2'b00,
    MODE_THR = 2'b01,
    MODE_ALL = 2'b10,
    MODE_ANY = 2'b11
  } mode_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/majority_vote_stream_if.sv
// Producer/consumer bundle for majority_vote_stream: input word handshake,
// vote controls, and the decision/filter results.
interface majority_vote_stream_if
  import majority_pkg::*;
#(
  parameter int N = 8
) ();

  localparam int CW = clog2(N + 1);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  x;
  logic [1:0]    mode;
  logic [CW-1:0] thr;
  logic          out_valid;
  logic          out_ready;
  logic          y;
  logic [CW-1:0] cnt;
  logic          tie;
  logic          y_filt;
  logic          hist_full;

  modport master (
    output in_valid, x, mode, thr, out_ready,
    input  in_ready, out_valid, y, cnt, tie, y_filt, hist_full
  );

  modport slave (
    input  in_valid, x, mode, thr, out_ready,
    output in_ready, out_valid, y, cnt, tie, y_filt, hist_full
  );

endinterface

// File: rtl/majority_popcount.sv
// Combinational popcount built as a balanced pairwise adder tree; inputs are
// zero-padded up to the next power of two.
module majority_popcount
  import majority_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = clog2(N + 1)
) (
  input  logic [N-1:0]  i_vec,
  output logic [CW-1:0] o_cnt
);

  localparam int LEVELS = clog2(N);
  localparam int P      = 1 << LEVELS;

  logic [P-1:0]  w_pad;
  logic [CW-1:0] w_lvl [LEVELS+1][P];

  always_comb begin
    w_pad          = '0;
    w_pad[N-1:0]   = i_vec;
    w_lvl          = '{default: '0};
    for (int i = 0; i < P; i++) begin
      w_lvl[0][i] = CW'(w_pad[i]);
    end
    for (int l = 1; l <= LEVELS; l++) begin
      for (int i = 0; i < (P >> l); i++) begin
        w_lvl[l][i] = w_lvl[l-1][2*i] + w_lvl[l-1][2*i+1];
      end
    end
  end

  assign o_cnt = w_lvl[LEVELS][0];

endmodule

// File: rtl/majority_vote_stream.sv
// Two-stage streaming vote: popcount, then mode decision, with a K-deep
// temporal majority filter over consumed decisions.
module majority_vote_stream
  import majority_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 5
) (
  input logic                    clk,
  input logic                    rst,
  majority_vote_stream_if.slave  bus
);

  localparam int CW = clog2(N + 1);
  localparam int HW = clog2(K + 1);

  logic          w_advance;
  logic          w_hs;
  logic [CW-1:0] w_pc;
  logic [HW-1:0] w_hist_pc;

  logic          r_vld_p1;
  logic [CW-1:0] r_pc_p1;
  mode_e         r_mode_p1;
  logic [CW-1:0] r_thr_p1;

  logic          r_vld_p2;
  logic          r_y_p2;
  logic          r_tie_p2;
  logic [CW-1:0] r_cnt_p2;

  logic [K-1:0]  r_hist;
  logic [HW-1:0] r_cons;

  function automatic logic decide(input logic [CW-1:0] c, input mode_e m,
                                  input logic [CW-1:0] t);
    case (m)
      MODE_MAJ: return c > CW'(N / 2);
      MODE_THR: return c >= t;
      MODE_ALL: return c == CW'(N);
      default:  return c != '0;
    endcase
  endfunction

  // A tie only exists when the vector splits exactly in half.
  function automatic logic is_tie(input logic [CW-1:0] c);
    return ((N % 2) == 0) && (c == CW'(N / 2));
  endfunction

  majority_popcount #(.N(N), .CW(CW)) u_pc_x (
    .i_vec (bus.x),
    .o_cnt (w_pc)
  );

  majority_popcount #(.N(K), .CW(HW)) u_pc_hist (
    .i_vec (r_hist),
    .o_cnt (w_hist_pc)
  );

  assign w_advance     = !r_vld_p2 || bus.out_ready;
  assign w_hs          = r_vld_p2 && bus.out_ready;
  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_vld_p2;
  assign bus.y         = r_y_p2;
  assign bus.cnt       = r_cnt_p2;
  assign bus.tie       = r_tie_p2;
  assign bus.y_filt    = w_hist_pc > HW'(K / 2);
  assign bus.hist_full = (r_cons == HW'(K));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else if (w_advance) begin
      r_vld_p1 <= bus.in_valid;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // Stage 1: popcount and the controls sampled with the accepted word.
  always_ff @(posedge clk) begin
    if (w_advance && bus.in_valid) begin
      r_pc_p1   <= w_pc;
      r_mode_p1 <= mode_e'(bus.mode);
      r_thr_p1  <= bus.thr;
    end
  end

  // Stage 2: decision, count and tie presented to the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_p2   <= 1'b0;
      r_cnt_p2 <= '0;
      r_tie_p2 <= 1'b0;
    end else if (w_advance && r_vld_p1) begin
      r_y_p2   <= decide(r_pc_p1, r_mode_p1, r_thr_p1);
      r_cnt_p2 <= r_pc_p1;
      r_tie_p2 <= is_tie(r_pc_p1);
    end
  end

  // History records each consumed decision; the consumed counter saturates at K.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= '0;
      r_cons <= '0;
    end else if (w_hs) begin
      r_hist <= (r_hist << 1) | K'(r_y_p2);
      if (r_cons != HW'(K)) r_cons <= r_cons + HW'(1);
    end
  end

endmodule

// File: doc/majority_vote_stream.md
MAJORITY_VOTE_STREAM -- requirements
Module: majority_vote_stream

Interface
REQ-001 Parameter N, default 8: input vector width; N >= 1.
REQ-002 Parameter K, default 5: temporal-filter window depth; odd, 1 <= K <= 31.
REQ-003 Parameter CW, derived as clog2(N+1): count width.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset: clk in 1 (all logic on rising edge); rst in 1.
REQ-005 Port in_valid  in  1: input word valid.
REQ-006 Port in_ready  out  1: block accepts the word this cycle.
REQ-007 Port x  in  N: vote vector.
REQ-008 Port mode  in  2: 00 strict majority, 01 threshold, 10 unanimous, 11 any.
REQ-009 Port thr  in  CW: threshold for mode 01.
REQ-010 Port out_valid  out  1: result valid.
REQ-011 Port out_ready  in  1: consumer accepts the result.
REQ-012 Port y  out  1: vote decision.
REQ-013 Port cnt  out  CW: popcount of the accepted x.
REQ-014 Port tie  out  1: N even and cnt == N/2.
REQ-015 Port y_filt  out  1: majority of the last K accepted y values.
REQ-016 Port hist_full  out  1: at least K results consumed since reset.

Function
REQ-017 Transfers SHALL occur on valid && ready only; x, mode and thr are sampled together on input acceptance.
REQ-018 Pipeline: stage 1 registers the popcount, mode and thr; stage 2 registers y, cnt and tie.
REQ-019 Latency SHALL be exactly 2 cycles from acceptance to out_valid with no backpressure; throughput 1 word/cycle.
REQ-020 advance = !out_valid || out_ready; in_ready = advance; both stages move only when advance = 1.
REQ-021 With advance = 0, all stage contents SHALL hold; no word is lost, duplicated or reordered; at most 2 words are in flight.
REQ-022 Stage 1 SHALL become empty (bubble) when advance = 1 and in_valid = 0.
REQ-023 Mode 00: y = (cnt > floor(N/2)).
REQ-024 Mode 01: y = (cnt >= thr); thr = 0 gives y = 1; thr > N gives y = 0.
REQ-025 Mode 10: y = (cnt == N).
REQ-026 Mode 11: y = (cnt != 0).
REQ-027 tie SHALL be independent of mode and always 0 for odd N.
REQ-028 History: a K-bit shift register that shifts in y on each output handshake (out_valid && out_ready).
REQ-029 y_filt SHALL equal (popcount(history) > K/2), derived from the history register, so it changes the cycle after the handshake.
REQ-030 hist_full SHALL be set once the history has recorded K handshakes and stays set until reset; the consumed-count counter saturates.
REQ-031 A handshake and a new acceptance in the same cycle SHALL both take effect.

Reset
REQ-032 With rst = 1 at a clock edge, the following SHALL clear, discarding in-flight words: stage valids, out_valid, y, cnt, tie, history, y_filt, hist_full and the counter.
REQ-033 in_ready SHALL be 1 in the first cycle after reset and no handshake occurs in a reset cycle.

Structure
REQ-034 Package majority_pkg SHALL hold the mode encodings MODE_MAJ, MODE_THR, MODE_ALL and MODE_ANY, plus a clog2 helper.
REQ-035 Sub-module majority_popcount (parameter N, combinational adder tree, CW-bit output) SHALL be used for the x popcount; the history popcount may reuse it with N = K.

Verification (N=8, K=5)
REQ-036 mode 00, x=8'h0F, out_ready=1 -> two cycles later out_valid=1, cnt=4, y=0, tie=1; x=8'h1F -> cnt=5, y=1, tie=0.
REQ-037 mode 10, x=8'hFF -> y=1; x=8'hFE -> y=0; mode 11, x=8'h00 -> y=0, x=8'h80 -> y=1; mode 01 thr=3, x=8'h07 -> y=1, thr=4 -> y=0.
REQ-038 Backpressure: out_ready=0, three words offered back to back -> first two accepted, in_ready=0 on third; release -> three results in order, values intact.
REQ-039 Filter: consume y = 1,1,1,1,1,0,0 -> y_filt=1 from after the 3rd handshake; hist_full=1 after the 5th; still 1 after the 7th (window 1,1,1,0,0).
REQ-040 Reset mid-stream with 2 words in flight -> next cycle out_valid=0, y_filt=0, hist_full=0, in_ready=1.
REQ-041 Exhaustive sweep: all 256 x values, mode 00, random out_ready -> every y and cnt matches a popcount reference model, with no drops.
